divider_unit: RTL and testbench
===============================

DIVIDER_UNIT -- requirements
Module: divider_unit

Interface
REQ-001 SHALL provide parameter: WIDTH, 32, operand/result width in bits; only 32 is supported.
REQ-002 SHALL provide port: clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL provide port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL provide port: div_valid_i  input  1  request strobe from the multicycle control FSM.
REQ-005 SHALL provide port: div_ready_o  output  1  unit can accept a request this cycle.
REQ-006 SHALL provide port: funct3_i  input  3  100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL provide port: dividend_i  input  WIDTH  rs1 operand, from the SrcA mux.
REQ-008 SHALL provide port: divisor_i  input  WIDTH  rs2 operand, from the SrcB mux.
REQ-009 SHALL provide port: result_o  output  WIDTH  quotient or remainder, feeding the result mux.
REQ-010 SHALL provide port: div_valid_o  output  1  one-cycle pulse; result_o is valid.
REQ-011 SHALL provide port: busy_o  output  1  high in CALC and DONE.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, DONE.
REQ-013 SHALL drive div_ready_o high only in IDLE.
REQ-014 Acceptance SHALL occur on an edge where div_valid_i=1 and the state is IDLE; operands and funct3_i are latched on that edge.
REQ-015 On acceptance with divisor_i=0, the FSM SHALL go directly to DONE.
REQ-016 On divide-by-zero, quotient SHALL be 0xFFFFFFFF and remainder SHALL equal the dividend.
REQ-017 On acceptance with signed op, dividend 0x80000000 and divisor 0xFFFFFFFF, the FSM SHALL go directly to DONE.
REQ-018 For that overflow case, quotient SHALL be 0x80000000 and remainder SHALL be 0.
REQ-019 Otherwise the FSM SHALL enter CALC with a 6-bit iteration counter at 0.
REQ-020 Signed ops SHALL divide operand magnitudes, using a 33-bit partial remainder.
REQ-021 CALC SHALL perform one restoring shift-subtract iteration per cycle for exactly 32 cycles, then enter DONE.
REQ-022 Signed quotient SHALL be negated when operand signs differ.
REQ-023 Signed remainder SHALL take the dividend's sign.
REQ-024 Sign fix-up SHALL be applied on entry to DONE.
REQ-025 Normal latency: div_valid_o SHALL be high in the cycle following the 32nd CALC edge, i.e. 33 cycles after the acceptance edge.
REQ-026 Special-case latency: div_valid_o SHALL be high in the cycle immediately after the acceptance edge.
REQ-027 DONE SHALL last exactly one cycle, assert div_valid_o, and return to IDLE.
REQ-028 result_o SHALL hold its value after DONE until the next completion.
REQ-029 div_valid_i in CALC or DONE SHALL be ignored, with no queuing.
REQ-030 Changes on funct3_i, dividend_i or divisor_i after acceptance SHALL have no effect.
REQ-031 Back-to-back requests SHALL be legal; a request asserted in the cycle after DONE is accepted.

Reset
REQ-032 On rst=1 at a clock edge, state SHALL go to IDLE and counter to 0.
REQ-033 On that reset, result_o SHALL go to 0, div_valid_o to 0, and div_ready_o SHALL read 1 in the following cycle.
REQ-034 Reset during CALC or DONE SHALL abort the operation, with no div_valid_o pulse for it.
REQ-035 Reset SHALL take priority over acceptance on the same edge.

Structure
REQ-036 Shared package divider_pkg SHALL hold the funct3 op encodings, the FSM state encoding, and the constant XLEN=32.
REQ-037 One combinational sub-module, divider_step, SHALL perform a single shift-subtract iteration and be instantiated once.

Verification
REQ-038 DIVU/REMU 100,7 -> result 14 / 2, div_valid_o exactly 33 cycles after acceptance.
REQ-039 DIV/REM 0xFFFFFFF9 (-7),2 -> result 0xFFFFFFFD (-3) / 0xFFFFFFFF (-1).
REQ-040 DIVU/REM 5,0 -> result 0xFFFFFFFF / 5, div_valid_o one cycle after acceptance.
REQ-041 DIV/REM 0x80000000,0xFFFFFFFF -> result 0x80000000 / 0, one-cycle latency.
REQ-042 rst pulsed at CALC iteration 10 -> div_ready_o=1 next cycle, no div_valid_o; new DIVU 9,3 then yields 3.
REQ-043 div_valid_i held high continuously with operands changed mid-CALC -> results reflect the latched operands only; consecutive ops are accepted the cycle after each DONE.

Source files
------------

// File: rtl/divider_pkg.sv
// divider_pkg: shared op encodings, FSM states and data width for the divider
package divider_pkg;

   localparam int XLEN = 32;

   typedef enum logic [2:0] {
      OP_DIV  = 3'b100,
      OP_DIVU = 3'b101,
      OP_REM  = 3'b110,
      OP_REMU = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_e;

endpackage

// File: rtl/divider_step.sv
// divider_step: one restoring shift-subtract iteration on a 33-bit partial remainder
module divider_step
   import divider_pkg::*;
(
   input  logic [XLEN:0]   rem,
   input  logic [XLEN-1:0] quo,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN:0]   rem_next,
   output logic [XLEN-1:0] quo_next
);

   logic [XLEN+1:0] diff;

   // shift the next dividend bit in, trial-subtract, restore when the trial borrows
   always_comb begin
      diff     = {rem, quo[XLEN-1]} - {2'b00, divisor};
      rem_next = diff[XLEN+1] ? {rem[XLEN-1:0], quo[XLEN-1]} : diff[XLEN:0];
      quo_next = {quo[XLEN-2:0], ~diff[XLEN+1]};
   end

endmodule

// File: rtl/divider_unit.sv
// divider_unit: multicycle RV32M DIV/DIVU/REM/REMU unit, 32 iterations per normal op
module divider_unit
   import divider_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             div_valid_i,
   output logic             div_ready_o,
   input  logic [2:0]       funct3_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] result_o,
   output logic             div_valid_o,
   output logic             busy_o
);

   state_e          state;
   logic [5:0]      count;
   logic [XLEN:0]   rem;
   logic [XLEN-1:0] quo;
   logic [XLEN-1:0] divisor;
   logic            rem_sel;
   logic            neg_q;
   logic            neg_r;
   logic            is_signed;
   logic            is_rem;
   logic            overflow;
   logic [XLEN-1:0] a_mag;
   logic [XLEN-1:0] b_mag;
   logic [XLEN:0]   rem_next;
   logic [XLEN-1:0] quo_next;
   logic [XLEN-1:0] q_fix;
   logic [XLEN-1:0] r_fix;

   assign div_ready_o = state == IDLE;
   assign busy_o      = state != IDLE;

   // decode the request and form operand magnitudes plus the final sign fix-up
   always_comb begin
      is_signed = funct3_i == OP_DIV || funct3_i == OP_REM;
      is_rem    = funct3_i == OP_REM || funct3_i == OP_REMU;
      overflow  = is_signed && dividend_i == {1'b1, {(XLEN-1){1'b0}}} && divisor_i == '1;
      a_mag     = is_signed && dividend_i[XLEN-1] ? -dividend_i : dividend_i;
      b_mag     = is_signed && divisor_i[XLEN-1] ? -divisor_i : divisor_i;
      q_fix     = neg_q ? -quo_next : quo_next;
      r_fix     = neg_r ? -rem_next[XLEN-1:0] : rem_next[XLEN-1:0];
   end

   divider_step u_step (
      .rem      (rem),
      .quo      (quo),
      .divisor  (divisor),
      .rem_next (rem_next),
      .quo_next (quo_next)
   );

   // control FSM: accept in IDLE, iterate 32 times in CALC, pulse the result in DONE
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         count       <= '0;
         result_o    <= '0;
         div_valid_o <= 1'b0;
         rem         <= '0;
         quo         <= '0;
         divisor     <= '0;
         rem_sel     <= 1'b0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
      end else begin
         case (state)
            IDLE: if (div_valid_i) begin
               rem_sel <= is_rem;
               neg_q   <= is_signed && (dividend_i[XLEN-1] ^ divisor_i[XLEN-1]);
               neg_r   <= is_signed && dividend_i[XLEN-1];
               count   <= '0;
               if (divisor_i == '0) begin
                  result_o    <= is_rem ? dividend_i : '1;
                  div_valid_o <= 1'b1;
                  state       <= DONE;
               end else if (overflow) begin
                  result_o    <= is_rem ? '0 : dividend_i;
                  div_valid_o <= 1'b1;
                  state       <= DONE;
               end else begin
                  rem     <= '0;
                  quo     <= a_mag;
                  divisor <= b_mag;
                  state   <= CALC;
               end
            end
            CALC: begin
               rem   <= rem_next;
               quo   <= quo_next;
               count <= count + 6'd1;
               if (count == 6'd31) begin
                  result_o    <= rem_sel ? r_fix : q_fix;
                  div_valid_o <= 1'b1;
                  state       <= DONE;
               end
            end
            DONE: begin
               div_valid_o <= 1'b0;
               count       <= '0;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_divider_unit.sv
// tb_divider_unit: randomized and directed checks of divider_unit against an arithmetic model
module tb_divider_unit;
   import divider_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        div_valid_i;
   logic        div_ready_o;
   logic [2:0]  funct3_i;
   logic [31:0] dividend_i;
   logic [31:0] divisor_i;
   logic [31:0] result_o;
   logic        div_valid_o;
   logic        busy_o;

   int checks = 0;
   int errors = 0;

   divider_unit #(.WIDTH(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .div_valid_i (div_valid_i),
      .div_ready_o (div_ready_o),
      .funct3_i    (funct3_i),
      .dividend_i  (dividend_i),
      .divisor_i   (divisor_i),
      .result_o    (result_o),
      .div_valid_o (div_valid_o),
      .busy_o      (busy_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // RISC-V M semantics straight from the arithmetic rules
   function automatic void model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] res, output int lat);
      bit sg = (f == OP_DIV) || (f == OP_REM);
      bit rm = f[1];
      logic [31:0] q, r;
      int sa, sb;
      if (b == 0) begin
         q = 32'hFFFF_FFFF; r = a; lat = 1;
      end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = a; r = 0; lat = 1;
      end else begin
         lat = 33;
         if (sg) begin
            sa = a; sb = b;
            q = sa / sb; r = sa % sb;
         end else begin
            q = a / b; r = a % b;
         end
      end
      res = rm ? r : q;
   endfunction

   task automatic wait_valid(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!div_valid_o && n < 40);
   endtask

   task automatic scramble();
      funct3_i   = 3'($urandom_range(4, 7));
      dividend_i = $urandom;
      divisor_i  = $urandom;
   endtask

   task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] exp;
      int lat, n;
      model(f, a, b, exp, lat);
      @(negedge clk);
      check("ready", 32'(div_ready_o), 32'd1);
      div_valid_i = 1'b1; funct3_i = f; dividend_i = a; divisor_i = b;
      @(posedge clk); #1;
      div_valid_i = 1'b0;
      scramble();
      wait_valid(n);
      check($sformatf("lat f%0d %h/%h", f, a, b), n, lat);
      check($sformatf("res f%0d %h/%h", f, a, b), result_o, exp);
      @(negedge clk);
      check("pulse_end", 32'(div_valid_o), 32'd0);
      check("hold", result_o, exp);
   endtask

   initial begin
      logic [31:0] a, b, exp_a, exp_b;
      logic [2:0]  f;
      int n, lat, pulses;
      rst = 1'b1; div_valid_i = 1'b0; funct3_i = OP_DIVU; dividend_i = 0; divisor_i = 0;
      @(posedge clk);
      @(negedge clk);
      check("rst_ready", 32'(div_ready_o), 32'd1);
      check("rst_valid", 32'(div_valid_o), 32'd0);
      check("rst_result", result_o, 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      rst = 1'b0;

      do_op(OP_DIVU, 100, 7);
      do_op(OP_REMU, 100, 7);
      do_op(OP_DIV, 32'hFFFF_FFF9, 2);
      do_op(OP_REM, 32'hFFFF_FFF9, 2);
      do_op(OP_DIVU, 5, 0);
      do_op(OP_REM, 5, 0);
      do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      do_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF);
      do_op(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF);

      // abort mid-CALC with reset
      @(negedge clk);
      div_valid_i = 1'b1; funct3_i = OP_DIVU; dividend_i = 100; divisor_i = 7;
      @(posedge clk); #1;
      div_valid_i = 1'b0;
      repeat (10) @(posedge clk);
      check("busy_calc", 32'(busy_o), 32'd1);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("abort_ready", 32'(div_ready_o), 32'd1);
      check("abort_result", result_o, 32'd0);
      pulses = 0;
      repeat (40) begin
         @(negedge clk);
         if (div_valid_o) pulses++;
      end
      check("abort_pulses", pulses, 0);
      do_op(OP_DIVU, 9, 3);

      // reset wins over a simultaneous request
      @(negedge clk);
      rst = 1'b1; div_valid_i = 1'b1; funct3_i = OP_DIVU; dividend_i = 9; divisor_i = 3;
      @(posedge clk); #1 rst = 1'b0; div_valid_i = 1'b0;
      @(negedge clk);
      check("rst_prio_busy", 32'(busy_o), 32'd0);

      // request held high, operands changed mid-CALC, back-to-back acceptance
      a = 32'd1000; b = 32'd33;
      model(OP_DIVU, a, b, exp_a, lat);
      model(OP_REM, 32'hFFFF_FC00, 32'd7, exp_b, lat);
      @(negedge clk);
      div_valid_i = 1'b1; funct3_i = OP_DIVU; dividend_i = a; divisor_i = b;
      @(posedge clk);
      repeat (5) @(posedge clk);
      #1 funct3_i = OP_REM; dividend_i = 32'hFFFF_FC00; divisor_i = 32'd7;
      wait_valid(n);
      check("b2b_lat1", n, 28);
      check("b2b_res1", result_o, exp_a);
      @(negedge clk);
      check("b2b_ready", 32'(div_ready_o), 32'd1);
      @(posedge clk); #1;
      div_valid_i = 1'b0;
      scramble();
      wait_valid(n);
      check("b2b_lat2", n, 33);
      check("b2b_res2", result_o, exp_b);

      // random ops
      for (int i = 0; i < 24; i++) begin
         f = 3'($urandom_range(4, 7));
         a = $urandom;
         case ($urandom_range(0, 9))
            0: b = 0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2, 3, 4: b = $urandom_range(1, 20);
            5: b = -$urandom_range(1, 20);
            default: b = $urandom;
         endcase
         do_op(f, a, b);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
